// File: rtl/zs_slice_pkg.sv
// Shared types for the zero-skip valid/ready slices (skid_slice, fifo_slice).
package zs_slice_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef logic [1:0] occ_t;

  // Number of held entries for a given slice state.
  function automatic occ_t occ_of(state_t s);
    occ_t o;
    case (s)
      EMPTY:   o = 2'd0;
      ONE:     o = 2'd1;
      TWO:     o = 2'd2;
      default: o = 2'd0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/skid_slice.sv
// Two-entry valid/ready register slice. Every output, including the upstream
// ready, comes straight from a flop, so no combinational path crosses the slice
// in either direction. main_q feeds the downstream port; skid_q catches the one
// beat that can arrive while the downstream stalls and rdy_o is still high.
//
// state | meaning
// EMPTY | nothing held, vld_o low
// ONE   | main_q valid, skid_q unused, ready upstream
// TWO   | main_q and skid_q valid, not ready upstream
module skid_slice
  import zs_slice_pkg::*;
#(
  parameter type t = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  t     din_i,
  input  logic vld_i,
  output logic rdy_o,
  output t     dout_o,
  output logic vld_o,
  input  logic rdy_i,
  output occ_t occ_o
);

  state_t state_q, state_d;
  t       main_q, main_d;
  t       skid_q, skid_d;
  logic   rdy_q, rdy_d;
  logic   acc, pop;

  assign acc = vld_i & rdy_q;
  assign pop = (state_q != EMPTY) & rdy_i;

  // Next state and data: handshake-driven moves, with clear_i overriding all of them.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = din_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          main_d = din_i;
        end else if (acc) begin
          skid_d  = din_i;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // rdy_q is low here, so only the drain of main_q can happen.
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (clear_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    // Ready is computed from the next state so the flop already reflects it.
    rdy_d = (state_d != TWO);
  end

  // State, storage and registered ready; reset leaves ready low for one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy_o  = rdy_q;
  assign vld_o  = (state_q != EMPTY);
  assign dout_o = main_q;
  assign occ_o  = occ_of(state_q);

endmodule

// File: tb/tb_skid_slice.sv
// Directed and random-stall bench for skid_slice with an 8-bit payload.
module tb_skid_slice;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clear_i;
  logic [7:0] din_i;
  logic       vld_i;
  logic       rdy_o;
  logic [7:0] dout_o;
  logic       vld_o;
  logic       rdy_i;
  logic [1:0] occ_o;

  int n_cmp = 0;
  int n_bad = 0;

  skid_slice #(.t(logic [7:0])) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(clear_i),
    .din_i  (din_i),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .dout_o (dout_o),
    .vld_o  (vld_o),
    .rdy_i  (rdy_i),
    .occ_o  (occ_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clear_i = 1'b0; din_i = 8'h00; vld_i = 1'b0; rdy_i = 1'b0;
    step(); step();
    n_cmp++; if (vld_o !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", vld_o); end
    n_cmp++; if (rdy_o !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", rdy_o); end
    n_cmp++; if (occ_o !== 2'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occ_o); end
    n_cmp++; if (dout_o !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h want 00", dout_o); end
    rst_i = 1'b0;
    #2;
    n_cmp++; if (rdy_o !== 1'b0) begin n_bad++; $display("FAIL release_rdy_before_edge got %b want 0", rdy_o); end
    step();
    n_cmp++; if (rdy_o !== 1'b1) begin n_bad++; $display("FAIL release_rdy_after_edge got %b want 1", rdy_o); end
  endtask

  task automatic test_streaming();
    logic [7:0] v;
    int rdy_low = 0;
    int bad_data = 0;
    rdy_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      v = k[7:0];
      din_i = v; vld_i = 1'b1;
      step();
      if (rdy_o !== 1'b1) rdy_low++;
      if (vld_o !== 1'b1 || dout_o !== v || occ_o !== 2'd1) begin
        bad_data++;
        $display("FAIL stream_beat got vld=%b dout=%h occ=%0d want vld=1 dout=%h occ=1", vld_o, dout_o, occ_o, v);
      end
    end
    vld_i = 1'b0;
    n_cmp++; if (bad_data !== 0) begin n_bad++; $display("FAIL stream_order got %0d bad beats want 0", bad_data); end
    n_cmp++; if (rdy_low !== 0) begin n_bad++; $display("FAIL stream_rdy got %0d low cycles want 0", rdy_low); end
    step();
    n_cmp++; if (occ_o !== 2'd0 || vld_o !== 1'b0) begin n_bad++; $display("FAIL stream_drain got occ=%0d vld=%b want occ=0 vld=0", occ_o, vld_o); end
  endtask

  task automatic test_skid();
    rdy_i = 1'b0;
    din_i = 8'hA1; vld_i = 1'b1;
    step();
    n_cmp++; if (occ_o !== 2'd1 || rdy_o !== 1'b1 || dout_o !== 8'hA1) begin n_bad++; $display("FAIL skid_first got occ=%0d rdy=%b dout=%h want occ=1 rdy=1 dout=a1", occ_o, rdy_o, dout_o); end
    din_i = 8'hA2;
    step();
    vld_i = 1'b0;
    n_cmp++; if (occ_o !== 2'd2) begin n_bad++; $display("FAIL skid_occ got %0d want 2", occ_o); end
    n_cmp++; if (rdy_o !== 1'b0) begin n_bad++; $display("FAIL skid_rdy got %b want 0", rdy_o); end
    n_cmp++; if (dout_o !== 8'hA1) begin n_bad++; $display("FAIL skid_dout got %h want a1", dout_o); end
    step();
    n_cmp++; if (occ_o !== 2'd2 || dout_o !== 8'hA1) begin n_bad++; $display("FAIL skid_hold got occ=%0d dout=%h want occ=2 dout=a1", occ_o, dout_o); end
    rdy_i = 1'b1;
    step();
    n_cmp++; if (occ_o !== 2'd1 || dout_o !== 8'hA2 || rdy_o !== 1'b1) begin n_bad++; $display("FAIL skid_pop1 got occ=%0d dout=%h rdy=%b want occ=1 dout=a2 rdy=1", occ_o, dout_o, rdy_o); end
    step();
    n_cmp++; if (occ_o !== 2'd0 || vld_o !== 1'b0) begin n_bad++; $display("FAIL skid_pop2 got occ=%0d vld=%b want occ=0 vld=0", occ_o, vld_o); end
  endtask

  task automatic test_clear();
    rdy_i = 1'b0;
    din_i = 8'h55; vld_i = 1'b1; step();
    din_i = 8'h66; step();
    n_cmp++; if (occ_o !== 2'd2) begin n_bad++; $display("FAIL clear_fill got occ=%0d want 2", occ_o); end
    clear_i = 1'b1; din_i = 8'h77; vld_i = 1'b1;
    step();
    clear_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b1;
    n_cmp++; if (occ_o !== 2'd0 || vld_o !== 1'b0 || rdy_o !== 1'b1 || dout_o !== 8'h00) begin n_bad++; $display("FAIL clear_two got occ=%0d vld=%b rdy=%b dout=%h want 0 0 1 00", occ_o, vld_o, rdy_o, dout_o); end
    step();
    n_cmp++; if (vld_o !== 1'b0) begin n_bad++; $display("FAIL clear_no_77 got vld=%b dout=%h want vld=0", vld_o, dout_o); end
    // Clear while a beat is actually handshaken (rdy_o high) must discard it.
    rdy_i = 1'b0; din_i = 8'h10; vld_i = 1'b1; step();
    clear_i = 1'b1; din_i = 8'h77; step();
    clear_i = 1'b0; vld_i = 1'b0;
    n_cmp++; if (occ_o !== 2'd0 || vld_o !== 1'b0 || rdy_o !== 1'b1) begin n_bad++; $display("FAIL clear_acc got occ=%0d vld=%b rdy=%b want 0 0 1", occ_o, vld_o, rdy_o); end
    step();
    n_cmp++; if (vld_o !== 1'b0) begin n_bad++; $display("FAIL clear_acc_drop got vld=%b dout=%h want vld=0", vld_o, dout_o); end
  endtask

  task automatic test_async_reset();
    rdy_i = 1'b0;
    din_i = 8'h31; vld_i = 1'b1; step();
    din_i = 8'h32; step();
    vld_i = 1'b0;
    n_cmp++; if (occ_o !== 2'd2) begin n_bad++; $display("FAIL arst_fill got occ=%0d want 2", occ_o); end
    #2 rst_i = 1'b1;
    #1;
    n_cmp++; if (vld_o !== 1'b0 || occ_o !== 2'd0 || rdy_o !== 1'b0 || dout_o !== 8'h00) begin n_bad++; $display("FAIL arst_now got vld=%b occ=%0d rdy=%b dout=%h want 0 0 0 00", vld_o, occ_o, rdy_o, dout_o); end
    step();
    rst_i = 1'b0; rdy_i = 1'b1;
    step();
    n_cmp++; if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin n_bad++; $display("FAIL arst_release got vld=%b rdy=%b want vld=0 rdy=1", vld_o, rdy_o); end
    din_i = 8'h40; vld_i = 1'b1; step();
    vld_i = 1'b0;
    n_cmp++; if (vld_o !== 1'b1 || dout_o !== 8'h40) begin n_bad++; $display("FAIL arst_fresh got vld=%b dout=%h want vld=1 dout=40", vld_o, dout_o); end
    step();
  endtask

  task automatic test_random_stalls();
    logic [7:0] q[$];
    logic [7:0] exp;
    logic [7:0] prev_dout;
    logic       prev_stall;
    logic       holding;
    logic       acc, pop;
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    int seq = 0;
    logic [7:0] seqb;
    holding = 1'b0; prev_stall = 1'b0; prev_dout = 8'h00;
    vld_i = 1'b0; rdy_i = 1'b0;
    while (recv < 10000 && cyc < 60000) begin
      if (occ_o !== 2'(q.size()) || vld_o !== (q.size() != 0) || rdy_o !== (q.size() != 2)) begin
        n_cmp++; n_bad++;
        $display("FAIL rand_state got occ=%0d vld=%b rdy=%b want occ=%0d", occ_o, vld_o, rdy_o, q.size());
      end else n_cmp++;
      if (prev_stall) begin
        n_cmp++;
        if (dout_o !== prev_dout) begin n_bad++; $display("FAIL rand_stable got %h want %h", dout_o, prev_dout); end
      end
      if (!holding) begin
        seqb = seq[7:0];
        vld_i = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
        din_i = seqb;
      end
      rdy_i = 1'($urandom_range(0, 1));
      acc = vld_i & rdy_o;
      pop = vld_o & rdy_i;
      if (pop) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rand_spurious got %h want none", dout_o);
        end else begin
          exp = q.pop_front();
          n_cmp++;
          if (dout_o !== exp) begin n_bad++; $display("FAIL rand_order got %h want %h", dout_o, exp); end
        end
        recv++;
      end
      if (acc) begin
        q.push_back(din_i);
        seq++; sent++;
      end
      holding = vld_i & ~acc;
      prev_stall = vld_o & ~rdy_i;
      prev_dout = dout_o;
      step();
      cyc++;
    end
    vld_i = 1'b0; rdy_i = 1'b0;
    n_cmp++;
    if (recv !== 10000) begin n_bad++; $display("FAIL rand_count got %0d beats want 10000", recv); end
    step();
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; din_i = 8'h00; vld_i = 1'b0; rdy_i = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_clear();
    test_async_reset();
    test_random_stalls();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
